// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage.
// Accepts a word-addressed PC and issues one memory read for it.
// The returned instruction and its PC are held for decode until consumed.
// A flush discards any in-flight or buffered instruction.
module instr_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              err_spurious
);

    // IDLE: ready for a PC. WAIT: read outstanding. FULL: instruction held
    // for decode. DRAIN: a flushed read is still outstanding and its data
    // must be swallowed before a new request may go out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   w_accept;
    logic   w_capture;
    logic   w_spurious;

    // Next-state, handshake and event decode; flush overrides every other input.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_spurious  = 1'b0;
        pc_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                pc_ready   = !flush;
                w_spurious = mem_rvalid;
                if (!flush && pc_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    w_nextState = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_nextState = FULL;
                end
            end
            FULL: begin
                pc_ready   = instr_ready && !flush;
                w_spurious = mem_rvalid;
                if (flush) begin
                    w_nextState = IDLE;
                end else if (instr_ready) begin
                    if (pc_valid) begin
                        w_accept    = 1'b1;
                        w_nextState = WAIT;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!flush && mem_rvalid) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, request strobe, address/instruction capture and sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            mem_req     <= w_accept;
            instr_valid <= (w_nextState == FULL);
            if (w_accept) begin
                mem_addr <= pc_in;
                instr_pc <= pc_in;
            end
            if (w_capture) begin
                instr <= mem_rdata;
            end
            if (w_spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {pc, instr} pairs are queued
// when a memory response is driven and popped when the instruction reaches decode.
module tb_instr_fetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clock;
   logic              reset;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_valid;
   logic              pc_ready;
   logic              flush;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              err_spurious;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .pc_in       (pc_in),
      .pc_valid    (pc_valid),
      .pc_ready    (pc_ready),
      .flush       (flush),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .err_spurious(err_spurious)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one PC from IDLE and answer it one cycle after mem_req; the
   // instruction is expected valid when this returns.
   task automatic applyStimulus(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] data);
      pc_in    = pc;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      expQ.push_back('{pc, data});
      tick();
      mem_rvalid = 1'b0;
   endtask

   // Let decode take the held instruction with no new PC offered.
   task automatic consume();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
      compared++; if (mem_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
      compared++; if (instr !== '0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
      compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
      compared++; if (err_spurious !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err_spurious); end
      compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_pc_ready: got %b expected 1", pc_ready); end
   endtask

   task automatic test_basic();
      exp_t e;
      pc_in    = 32'h0;
      pc_valid = 1'b1;
      #1;
      compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_pc_ready: got %b expected 1", pc_ready); end
      tick();
      pc_valid = 1'b0;
      #1;
      compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_mem_req_hi: got %b expected 1", mem_req); end
      compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL basic_mem_addr: got %h expected 0", mem_addr); end
      compared++; if (pc_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_wait_pc_ready: got %b expected 0", pc_ready); end
      tick();
      compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_mem_req_pulse: got %b expected 0", mem_req); end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h2008000A;
      expQ.push_back('{32'h0, 32'h2008000A});
      tick();
      mem_rvalid = 1'b0;
      e = expQ[0];
      compared++; if (instr_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_instr_valid: got %b expected 1", instr_valid); end
      compared++; if (instr !== e.data) begin mismatched++; $display("[TB] FAIL basic_instr: got %h expected %h", instr, e.data); end
      compared++; if (instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL basic_instr_pc: got %h expected %h", instr_pc, e.pc); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      e = expQ[0];
      pc_in       = 32'h1;
      pc_valid    = 1'b1;
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         compared++; if (pc_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_pc_ready_%0d: got %b expected 0", i, pc_ready); end
         compared++; if (instr !== e.data || instr_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_%0d: got %h/%b expected %h/1", i, instr, instr_valid, e.data); end
         tick();
      end
      instr_ready = 1'b1;
      #1;
      compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_pc_ready: got %b expected 1", pc_ready); end
      e = expQ.pop_front();
      compared++; if (instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL bp_consume: got %h@%h expected %h@%h", instr, instr_pc, e.data, e.pc); end
      tick();
      instr_ready = 1'b0;
      pc_valid    = 1'b0;
      compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_b2b_valid: got %b expected 0", instr_valid); end
      compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h1) begin mismatched++; $display("[TB] FAIL bp_b2b_req: got %b@%h expected 1@00000001", mem_req, mem_addr); end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A50001;
      expQ.push_back('{32'h1, 32'hA5A50001});
      tick();
      mem_rvalid = 1'b0;
      e = expQ.pop_front();
      compared++; if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL bp_second: got %b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, e.data, e.pc); end
      consume();
      compared++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_idle: got valid=%b ready=%b expected 0/1", instr_valid, pc_ready); end
   endtask

   task automatic test_flush_wait();
      exp_t e;
      pc_in    = 32'h20;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fw_mem_req: got %b expected 1", mem_req); end
      tick();
      flush = 1'b1;
      #1;
      compared++; if (pc_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL fw_flush_pc_ready: got %b expected 0", pc_ready); end
      tick();
      flush    = 1'b0;
      pc_in    = 32'h40;
      pc_valid = 1'b1;
      #1;
      compared++; if (pc_ready !== 1'b0 || instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fw_drain1: got ready=%b valid=%b expected 0/0", pc_ready, instr_valid); end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      #1;
      compared++; if (pc_ready !== 1'b0 || mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL fw_drain2: got ready=%b req=%b expected 0/0", pc_ready, mem_req); end
      tick();
      mem_rvalid = 1'b0;
      #1;
      compared++; if (instr_valid !== 1'b0 || instr !== 32'hA5A50001) begin mismatched++; $display("[TB] FAIL fw_discard: got %b %h expected 0 a5a50001", instr_valid, instr); end
      compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL fw_idle_ready: got %b expected 1", pc_ready); end
      tick();
      pc_valid = 1'b0;
      compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin mismatched++; $display("[TB] FAIL fw_refetch_req: got %b@%h expected 1@00000040", mem_req, mem_addr); end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h40404040;
      expQ.push_back('{32'h40, 32'h40404040});
      tick();
      mem_rvalid = 1'b0;
      e = expQ.pop_front();
      compared++; if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL fw_refetch: got %b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, e.data, e.pc); end
      consume();
   endtask

   task automatic test_flush_full();
      exp_t e;
      applyStimulus(32'h50, 32'h50505050);
      e = expQ.pop_front();
      compared++; if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL ff_full: got %b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, e.data, e.pc); end
      flush       = 1'b1;
      instr_ready = 1'b1;
      pc_valid    = 1'b1;
      pc_in       = 32'h51;
      #1;
      compared++; if (pc_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ff_pc_ready: got %b expected 0", pc_ready); end
      tick();
      flush       = 1'b0;
      instr_ready = 1'b0;
      pc_valid    = 1'b0;
      #1;
      compared++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL ff_dropped: got valid=%b req=%b expected 0/0", instr_valid, mem_req); end
      compared++; if (pc_ready !== 1'b1 || instr_pc !== 32'h50) begin mismatched++; $display("[TB] FAIL ff_idle: got ready=%b pc=%h expected 1/00000050", pc_ready, instr_pc); end
   endtask

   task automatic test_spurious();
      exp_t e;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      compared++; if (err_spurious !== 1'b1) begin mismatched++; $display("[TB] FAIL sp_set: got %b expected 1", err_spurious); end
      compared++; if (instr !== 32'h50505050 || instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sp_instr: got %h/%b expected 50505050/0", instr, instr_valid); end
      applyStimulus(32'h60, 32'h60606060);
      e = expQ.pop_front();
      compared++; if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL sp_fetch: got %b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, e.data, e.pc); end
      consume();
      compared++; if (err_spurious !== 1'b1) begin mismatched++; $display("[TB] FAIL sp_sticky: got %b expected 1", err_spurious); end
   endtask

   task automatic test_async_reset();
      exp_t e;
      pc_in    = 32'h70;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_wait_req: got %b expected 1", mem_req); end
      #2;
      reset = 1'b1;
      #1;
      compared++; if (mem_req !== 1'b0 || mem_addr !== '0 || instr_pc !== '0) begin mismatched++; $display("[TB] FAIL ar_req_addr: got %b %h %h expected 0 0 0", mem_req, mem_addr, instr_pc); end
      compared++; if (instr !== '0 || instr_valid !== 1'b0 || err_spurious !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_instr_err: got %h %b %b expected 0 0 0", instr, instr_valid, err_spurious); end
      @(posedge clock);
      #3;
      reset = 1'b0;
      tick();
      applyStimulus(32'h10, 32'h10101010);
      e = expQ.pop_front();
      compared++; if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin mismatched++; $display("[TB] FAIL ar_refetch: got %b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, e.data, e.pc); end
      compared++; if (err_spurious !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_err_clear: got %b expected 0", err_spurious); end
      consume();
   endtask

   // Sequence all scenarios, then report.
   initial begin
      reset       = 1'b1;
      pc_in       = '0;
      pc_valid    = 1'b0;
      flush       = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_wait();
      test_flush_full();
      test_spurious();
      test_async_reset();
      compared++; if (expQ.size() != 0) begin mismatched++; $display("[TB] FAIL scoreboard_empty: got %0d left expected 0", expQ.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
